// File: rtl/sparse_gf2_mult.sv
// Streaming GF(2) sparse matrix-vector multiplier: y = A*x with A held in a
// runtime-loadable column table of {en, row} slots, x streamed in, y drained out.
module sparse_gf2_mult #(
  parameter int IN_WIDTH      = 8,
  parameter int OUT_WIDTH     = 96,
  parameter int NUM_IN_WORDS  = 144,
  parameter int NUM_OUT_WORDS = 11,
  parameter int COL_WEIGHT    = 3,
  localparam int NUM_COLS     = IN_WIDTH * NUM_IN_WORDS,
  localparam int NUM_ROWS     = OUT_WIDTH * NUM_OUT_WORDS,
  localparam int COL_W        = $clog2(NUM_COLS),
  localparam int ROW_W        = $clog2(NUM_ROWS),
  localparam int SLOT_W       = (COL_WEIGHT > 1) ? $clog2(COL_WEIGHT) : 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [IN_WIDTH-1:0]  i_input_data,
  input  logic                 i_input_valid,
  output logic                 o_input_ready,
  output logic [OUT_WIDTH-1:0] o_output_data,
  output logic                 o_output_valid,
  input  logic                 i_output_ready,
  input  logic                 i_cfg_valid,
  input  logic [COL_W-1:0]     i_cfg_col,
  input  logic [SLOT_W-1:0]    i_cfg_slot,
  input  logic [ROW_W-1:0]     i_cfg_row,
  input  logic                 i_cfg_en,
  output logic                 o_cfg_ready,
  output logic [1:0]           o_dbg_state
);

  localparam int IN_CNT_W  = (NUM_IN_WORDS > 1) ? $clog2(NUM_IN_WORDS) : 1;
  localparam int OUT_CNT_W = (NUM_OUT_WORDS > 1) ? $clog2(NUM_OUT_WORDS) : 1;
  localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(NUM_IN_WORDS - 1);
  localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(NUM_OUT_WORDS - 1);
  localparam logic [COL_W:0]       COL_LIM  = (COL_W + 1)'(NUM_COLS);
  localparam logic [ROW_W:0]       ROW_LIM  = (ROW_W + 1)'(NUM_ROWS);
  localparam logic [SLOT_W:0]      SLOT_LIM = (SLOT_W + 1)'(COL_WEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Handshakes: a word moves on a rising edge where valid and ready are both
  // high; valid never waits on ready, and ready here may depend on i_cfg_valid.
  state_t                 state_q, state_d;
  logic [IN_CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [OUT_CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [NUM_ROWS-1:0]    acc_q, acc_d;
  logic                   rst_done_q, rst_done_d;

  logic                   tbl_en_q  [NUM_COLS][COL_WEIGHT];
  logic [ROW_W-1:0]       tbl_row_q [NUM_COLS][COL_WEIGHT];

  logic                   in_hs, out_hs, in_last, out_last, cfg_commit;
  logic [COL_W-1:0]       word_col_base, col;
  logic [ROW_W-1:0]       row, out_base;

  // Ready is held low for one cycle after reset so nothing lands mid-reset.
  assign o_cfg_ready    = rst_done_q && (state_q == ST_IDLE);
  assign o_input_ready  = rst_done_q && ((state_q == ST_ACCUM) ||
                                         ((state_q == ST_IDLE) && !i_cfg_valid));
  assign o_output_valid = (state_q == ST_DRAIN);
  assign o_dbg_state    = state_q;

  assign in_hs    = i_input_valid && o_input_ready;
  assign out_hs   = o_output_valid && i_output_ready;
  assign in_last  = (in_cnt_q == IN_LAST);
  assign out_last = (out_cnt_q == OUT_LAST);

  assign cfg_commit = i_cfg_valid && o_cfg_ready &&
                      ({1'b0, i_cfg_col} < COL_LIM) &&
                      ({1'b0, i_cfg_slot} < SLOT_LIM) &&
                      ({1'b0, i_cfg_row} < ROW_LIM);

  assign word_col_base = COL_W'(in_cnt_q) * COL_W'(IN_WIDTH);
  assign out_base      = ROW_W'(out_cnt_q) * ROW_W'(OUT_WIDTH);

  always_comb begin
    o_output_data = '0;
    if (state_q == ST_DRAIN) o_output_data = acc_q[out_base +: OUT_WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    rst_done_d = 1'b1;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (in_hs) begin
          if (in_last) begin
            state_d  = ST_DRAIN;
            in_cnt_d = '0;
          end else begin
            state_d  = ST_ACCUM;
            in_cnt_d = in_cnt_q + IN_CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_hs) begin
          if (out_last) begin
            state_d   = ST_IDLE;
            out_cnt_d = '0;
          end else begin
            out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every contribution of one word toggles its row, so duplicates cancel.
  always_comb begin
    acc_d = acc_q;
    col   = '0;
    row   = '0;
    if (out_hs && out_last) begin
      acc_d = '0;
    end else if (in_hs) begin
      for (int b = 0; b < IN_WIDTH; b++) begin
        for (int s = 0; s < COL_WEIGHT; s++) begin
          col = word_col_base + COL_W'(b);
          row = tbl_row_q[col][s];
          if (i_input_data[b] && tbl_en_q[col][s] && ({1'b0, row} < ROW_LIM))
            acc_d[row] = ~acc_d[row];
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      acc_q      <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      acc_q      <= acc_d;
      rst_done_q <= rst_done_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int c = 0; c < NUM_COLS; c++)
        for (int s = 0; s < COL_WEIGHT; s++)
          tbl_en_q[c][s] <= 1'b0;
    end else if (cfg_commit) begin
      tbl_en_q[i_cfg_col][i_cfg_slot] <= i_cfg_en;
    end
  end

  // Row fields need no reset: a slot only matters once its enable is set.
  always_ff @(posedge i_clock) begin
    if (cfg_commit) tbl_row_q[i_cfg_col][i_cfg_slot] <= i_cfg_row;
  end

endmodule

// File: tb/tb_sparse_gf2_mult.sv
// Directed bench for sparse_gf2_mult: reset, empty table, sparse cancellation,
// output stalls, config arbitration and reset during drain.
`timescale 1ns/1ps
module tb_sparse_gf2_mult;

  localparam int IW     = 8;
  localparam int OW     = 96;
  localparam int NIW    = 144;
  localparam int NOW    = 11;
  localparam int CW     = 3;
  localparam int COL_W  = 11;
  localparam int ROW_W  = 11;
  localparam int SLOT_W = 2;

  logic              i_clock;
  logic              i_reset_n;
  logic [IW-1:0]     i_input_data;
  logic              i_input_valid;
  logic              o_input_ready;
  logic [OW-1:0]     o_output_data;
  logic              o_output_valid;
  logic              i_output_ready;
  logic              i_cfg_valid;
  logic [COL_W-1:0]  i_cfg_col;
  logic [SLOT_W-1:0] i_cfg_slot;
  logic [ROW_W-1:0]  i_cfg_row;
  logic              i_cfg_en;
  logic              o_cfg_ready;
  logic [1:0]        o_dbg_state;

  int n_vec;
  int n_bad;
  logic [OW-1:0] got_q[$];
  logic [OW-1:0] exp_q[$];

  sparse_gf2_mult #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_IN_WORDS(NIW),
    .NUM_OUT_WORDS(NOW), .COL_WEIGHT(CW)
  ) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_input_data(i_input_data), .i_input_valid(i_input_valid),
    .o_input_ready(o_input_ready), .o_output_data(o_output_data),
    .o_output_valid(o_output_valid), .i_output_ready(i_output_ready),
    .i_cfg_valid(i_cfg_valid), .i_cfg_col(i_cfg_col), .i_cfg_slot(i_cfg_slot),
    .i_cfg_row(i_cfg_row), .i_cfg_en(i_cfg_en), .o_cfg_ready(o_cfg_ready),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [IW-1:0] d);
    int t;
    i_input_valid = 1'b1;
    i_input_data  = d;
    #1;
    t = 0;
    while (!o_input_ready && t < 50) begin
      @(negedge i_clock); #1; t++;
    end
    if (!o_input_ready) begin
      n_vec++; n_bad++;
      $display("FAIL send_word_timeout: ready=%0b required 1", o_input_ready);
    end
    @(negedge i_clock);
    i_input_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [IW-1:0] w0, input logic [IW-1:0] w1,
                            input logic [IW-1:0] rest);
    send_word(w0);
    send_word(w1);
    for (int k = 2; k < NIW; k++) send_word(rest);
  endtask

  task automatic cfg_write(input logic [COL_W-1:0] col, input logic [SLOT_W-1:0] slot,
                           input logic [ROW_W-1:0] row, input logic en);
    int t;
    i_cfg_valid = 1'b1;
    i_cfg_col   = col;
    i_cfg_slot  = slot;
    i_cfg_row   = row;
    i_cfg_en    = en;
    #1;
    t = 0;
    while (!o_cfg_ready && t < 50) begin
      @(negedge i_clock); #1; t++;
    end
    if (!o_cfg_ready) begin
      n_vec++; n_bad++;
      $display("FAIL cfg_write_timeout: cfg_ready=%0b required 1", o_cfg_ready);
    end
    @(negedge i_clock);
    i_cfg_valid = 1'b0;
  endtask

  // Collects up to n output words into got_q; tracks data changes during stalls.
  task automatic drain(input int n, input bit toggle, output int got_n, output int stall_bad);
    int cycles;
    bit phase;
    bit have_stall;
    logic [OW-1:0] stall_data;
    got_q.delete();
    got_n = 0; stall_bad = 0; cycles = 0; phase = 1'b0; have_stall = 1'b0;
    stall_data = '0;
    while (got_n < n && cycles < 300) begin
      i_output_ready = toggle ? phase : 1'b1;
      phase = ~phase;
      if (o_output_valid) begin
        if (have_stall && o_output_data !== stall_data) stall_bad++;
        if (i_output_ready) begin
          got_q.push_back(o_output_data);
          got_n++;
          have_stall = 1'b0;
        end else begin
          have_stall = 1'b1;
          stall_data = o_output_data;
        end
      end
      @(negedge i_clock);
      cycles++;
    end
    i_output_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clock);
    n_vec++; if (o_input_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %0b expected 0", o_input_ready); end
    n_vec++; if (o_cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_ready: got %0b expected 0", o_cfg_ready); end
    n_vec++; if (o_output_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b expected 0", o_output_valid); end
    n_vec++; if (o_output_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h expected 0", o_output_data); end
    n_vec++; if (o_dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", o_dbg_state); end
    i_reset_n = 1'b1;
    #1;
    n_vec++; if (o_input_ready !== 1'b0) begin n_bad++; $display("FAIL post_rst_in_ready: got %0b expected 0", o_input_ready); end
    n_vec++; if (o_cfg_ready !== 1'b0) begin n_bad++; $display("FAIL post_rst_cfg_ready: got %0b expected 0", o_cfg_ready); end
    @(negedge i_clock);
    n_vec++; if (o_input_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready: got %0b expected 1", o_input_ready); end
    n_vec++; if (o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cfg_ready: got %0b expected 1", o_cfg_ready); end
  endtask

  task automatic test_idle_quiet();
    int cnt;
    cnt = 0;
    i_output_ready = 1'b1;
    repeat (100) begin
      @(negedge i_clock);
      if (o_output_valid) cnt++;
    end
    i_output_ready = 1'b0;
    n_vec++; if (cnt !== 0) begin n_bad++; $display("FAIL idle_quiet: got %0d valid cycles expected 0", cnt); end
  endtask

  task automatic test_empty_table();
    int got_n, stall_bad;
    send_word(8'hFF);
    n_vec++; if (o_cfg_ready !== 1'b0) begin n_bad++; $display("FAIL accum_cfg_ready: got %0b expected 0", o_cfg_ready); end
    for (int k = 1; k < NIW; k++) send_word(8'hFF);
    n_vec++; if (o_input_ready !== 1'b0) begin n_bad++; $display("FAIL drain_in_ready: got %0b expected 0", o_input_ready); end
    n_vec++; if (o_output_valid !== 1'b1) begin n_bad++; $display("FAIL latency_valid: got %0b expected 1", o_output_valid); end
    exp_q.delete();
    for (int j = 0; j < NOW; j++) exp_q.push_back('0);
    drain(NOW, 1'b0, got_n, stall_bad);
    n_vec++; if (got_n !== NOW) begin n_bad++; $display("FAIL empty_count: got %0d expected %0d", got_n, NOW); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_vec++; if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL empty_word%0d: got %h expected %h", j, got_q[j], exp_q[j]); end
    end
    n_vec++; if (o_input_ready !== 1'b1) begin n_bad++; $display("FAIL after_drain_in_ready: got %0b expected 1", o_input_ready); end
    n_vec++; if (o_output_valid !== 1'b0) begin n_bad++; $display("FAIL after_drain_valid: got %0b expected 0", o_output_valid); end
  endtask

  task automatic test_sparse();
    int got_n, stall_bad;
    logic [OW-1:0] w;
    cfg_write(11'd0, 2'd0, 11'd5, 1'b1);
    cfg_write(11'd9, 2'd0, 11'd100, 1'b1);
    cfg_write(11'd9, 2'd1, 11'd5, 1'b1);
    send_frame(8'h01, 8'h02, 8'h00);
    exp_q.delete();
    for (int j = 0; j < NOW; j++) begin
      w = '0;
      if (j == 1) w[4] = 1'b1;
      exp_q.push_back(w);
    end
    drain(NOW, 1'b0, got_n, stall_bad);
    n_vec++; if (got_n !== NOW) begin n_bad++; $display("FAIL sparse_count: got %0d expected %0d", got_n, NOW); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_vec++; if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL sparse_word%0d: got %h expected %h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_back_to_back_stall();
    int got_n, stall_bad;
    send_frame(8'h01, 8'h02, 8'h00);
    drain(NOW, 1'b1, got_n, stall_bad);
    n_vec++; if (got_n !== NOW) begin n_bad++; $display("FAIL stall_count: got %0d expected %0d", got_n, NOW); end
    n_vec++; if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes expected 0", stall_bad); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_vec++; if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL stall_word%0d: got %h expected %h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_cfg_arbitration();
    int got_n, stall_bad;
    logic [OW-1:0] w;
    // Config attempt during ACCUM must be ignored.
    send_word(8'h01);
    i_cfg_valid = 1'b1; i_cfg_col = 11'd0; i_cfg_slot = 2'd0; i_cfg_row = 11'd0; i_cfg_en = 1'b1;
    i_input_valid = 1'b1; i_input_data = 8'h02;
    #1;
    n_vec++; if (o_cfg_ready !== 1'b0) begin n_bad++; $display("FAIL accum_cfg_ignored: got %0b expected 0", o_cfg_ready); end
    n_vec++; if (o_input_ready !== 1'b1) begin n_bad++; $display("FAIL accum_in_ready: got %0b expected 1", o_input_ready); end
    @(negedge i_clock);
    i_cfg_valid = 1'b0; i_input_valid = 1'b0;
    for (int k = 2; k < NIW; k++) send_word(8'h00);
    drain(NOW, 1'b0, got_n, stall_bad);
    n_vec++; if (got_n !== NOW) begin n_bad++; $display("FAIL ign_count: got %0d expected %0d", got_n, NOW); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_vec++; if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL ign_word%0d: got %h expected %h", j, got_q[j], exp_q[j]); end
    end
    // In IDLE the config write wins over a simultaneous input word.
    i_cfg_valid = 1'b1; i_cfg_col = 11'd0; i_cfg_slot = 2'd0; i_cfg_row = 11'd0; i_cfg_en = 1'b1;
    i_input_valid = 1'b1; i_input_data = 8'h01;
    #1;
    n_vec++; if (o_input_ready !== 1'b0) begin n_bad++; $display("FAIL cfg_wins_in_ready: got %0b expected 0", o_input_ready); end
    n_vec++; if (o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL cfg_wins_cfg_ready: got %0b expected 1", o_cfg_ready); end
    @(negedge i_clock);
    i_cfg_valid = 1'b0;
    n_vec++; if (o_dbg_state !== 2'd0) begin n_bad++; $display("FAIL cfg_wins_state: got %0d expected 0", o_dbg_state); end
    send_frame(8'h01, 8'h02, 8'h00);
    exp_q.delete();
    for (int j = 0; j < NOW; j++) begin
      w = '0;
      if (j == 0) begin w[0] = 1'b1; w[5] = 1'b1; end
      if (j == 1) w[4] = 1'b1;
      exp_q.push_back(w);
    end
    drain(NOW, 1'b0, got_n, stall_bad);
    n_vec++; if (got_n !== NOW) begin n_bad++; $display("FAIL commit_count: got %0d expected %0d", got_n, NOW); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_vec++; if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL commit_word%0d: got %h expected %h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_reset_mid_drain();
    int got_n, stall_bad;
    logic [OW-1:0] w;
    send_frame(8'h01, 8'h02, 8'h00);
    drain(5, 1'b0, got_n, stall_bad);
    n_vec++; if (got_n !== 5) begin n_bad++; $display("FAIL part_count: got %0d expected 5", got_n); end
    w = '0; w[0] = 1'b1; w[5] = 1'b1;
    if (got_q.size() > 0) begin
      n_vec++; if (got_q[0] !== w) begin n_bad++; $display("FAIL part_word0: got %h expected %h", got_q[0], w); end
    end
    i_reset_n = 1'b0;
    @(negedge i_clock);
    n_vec++; if (o_output_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %0b expected 0", o_output_valid); end
    n_vec++; if (o_output_data !== '0) begin n_bad++; $display("FAIL midrst_data: got %h expected 0", o_output_data); end
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clock);
    send_frame(8'hFF, 8'hFF, 8'hFF);
    drain(NOW, 1'b0, got_n, stall_bad);
    n_vec++; if (got_n !== NOW) begin n_bad++; $display("FAIL cleared_count: got %0d expected %0d", got_n, NOW); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_vec++; if (got_q[j] !== '0) begin n_bad++; $display("FAIL cleared_word%0d: got %h expected 0", j, got_q[j]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0; n_bad = 0;
    i_reset_n = 1'b0; i_input_data = '0; i_input_valid = 1'b0; i_output_ready = 1'b0;
    i_cfg_valid = 1'b0; i_cfg_col = '0; i_cfg_slot = '0; i_cfg_row = '0; i_cfg_en = 1'b0;
    test_reset();
    test_idle_quiet();
    test_empty_table();
    test_sparse();
    test_back_to_back_stall();
    test_cfg_arbitration();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
